// File: rtl/qam_symbol_sampler.sv
// 16-QAM symbol sampler: decimates matched-filter I/Q samples to the symbol rate, slices them and queues Gray codes.
// Define QAM_SLICER_ERR_EN to add err_i/err_q slicer-error outputs carried through the symbol FIFO.
module qam_symbol_sampler #(
    parameter int        DATA_W     = 32,
    parameter int signed THRESH     = 32'sd1073741824,
    parameter int        FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [1:0]               baud_rate,
    input  logic [4:0]               sample_phase,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic signed [DATA_W-1:0] sample_q,
    output logic                     sym_valid,
    input  logic                     sym_ready,
    output logic [3:0]               sym_code,
    output logic                     overflow
`ifdef QAM_SLICER_ERR_EN
    ,
    output logic signed [15:0]       err_i,
    output logic signed [15:0]       err_q
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef QAM_SLICER_ERR_EN
    localparam int ENTRY_W = 36;
`else
    localparam int ENTRY_W = 4;
`endif
    localparam logic signed [DATA_W-1:0] THR  = DATA_W'(THRESH);
    localparam logic signed [DATA_W-1:0] ZERO = '0;
    localparam logic [AW:0]              PTR_ONE = (AW+1)'(1);

    function automatic logic [1:0] sliceAxis(input logic signed [DATA_W-1:0] x);
        if (x < -THR)
            sliceAxis = 2'b00;
        else if (x < ZERO)
            sliceAxis = 2'b01;
        else if (x < THR)
            sliceAxis = 2'b11;
        else
            sliceAxis = 2'b10;
    endfunction

`ifdef QAM_SLICER_ERR_EN
    localparam int EW = DATA_W + 2;
    localparam logic signed [EW-1:0] THR_X     = EW'(THR);
    localparam logic signed [EW-1:0] IDEAL_IN  = THR_X >>> 1;
    localparam logic signed [EW-1:0] IDEAL_OUT = (THR_X + (THR_X <<< 1)) >>> 1;

    // Two guard bits keep x minus the outer ideal level from wrapping before the shift.
    function automatic logic signed [15:0] sliceErr(input logic signed [DATA_W-1:0] x,
                                                    input logic [1:0] code);
        logic signed [EW-1:0] ideal;
        logic signed [EW-1:0] diff;
        logic signed [EW-1:0] shifted;
        case (code)
            2'b00:   ideal = -IDEAL_OUT;
            2'b01:   ideal = -IDEAL_IN;
            2'b11:   ideal = IDEAL_IN;
            default: ideal = IDEAL_OUT;
        endcase
        diff    = EW'(x) - ideal;
        shifted = diff >>> (DATA_W - 16);
        if (shifted > EW'(32767))
            sliceErr = 16'sd32767;
        else if (shifted < EW'(-32767))
            sliceErr = -16'sd32767;
        else
            sliceErr = shifted[15:0];
    endfunction
`endif

    logic [1:0]               baud_q;
    logic [4:0]               cnt_q, cnt_d;
    logic [4:0]               spsMask, phase;
    logic                     baudChange, advance, strobe;
    logic                     s1Valid_q;
    logic signed [DATA_W-1:0] s1I_q, s1Q_q;
    logic [1:0]               codeI, codeQ;
    logic [ENTRY_W-1:0]       entry, head;
    logic [ENTRY_W-1:0]       mem_q [FIFO_DEPTH];
    logic [AW:0]              wrPtr_q, rdPtr_q;
    logic                     overflow_q;
    logic                     fifoEmpty, fifoFull, doPush, doPop;

    always_comb begin
        case (baud_rate)
            2'b00:   spsMask = 5'd31;
            2'b01:   spsMask = 5'd15;
            2'b10:   spsMask = 5'd7;
            default: spsMask = 5'd3;
        endcase
    end

    assign phase      = sample_phase & spsMask;
    assign baudChange = baud_rate != baud_q;
    assign advance    = enable && in_valid;
    assign strobe     = advance && !baudChange && (cnt_q == phase);

    // A rate change realigns the symbol counter and suppresses that cycle's strobe.
    always_comb begin
        cnt_d = cnt_q;
        if (baudChange)
            cnt_d = '0;
        else if (advance)
            cnt_d = (cnt_q == spsMask) ? 5'd0 : cnt_q + 5'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_q    <= '0;
            cnt_q     <= '0;
            s1Valid_q <= 1'b0;
            s1I_q     <= '0;
            s1Q_q     <= '0;
        end else begin
            baud_q    <= baud_rate;
            cnt_q     <= cnt_d;
            s1Valid_q <= strobe;
            if (strobe) begin
                s1I_q <= sample_i;
                s1Q_q <= sample_q;
            end
        end
    end

    assign codeI = sliceAxis(s1I_q);
    assign codeQ = sliceAxis(s1Q_q);
`ifdef QAM_SLICER_ERR_EN
    assign entry = {sliceErr(s1I_q, codeI), sliceErr(s1Q_q, codeQ), codeI, codeQ};
`else
    assign entry = {codeI, codeQ};
`endif

    assign fifoEmpty = wrPtr_q == rdPtr_q;
    assign fifoFull  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
    assign doPop     = !fifoEmpty && sym_ready;
    assign doPush    = s1Valid_q && (!fifoFull || doPop);

    // A pop frees the slot in the same cycle, so push-while-full only drops without a pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q[AW-1:0]] <= entry;
                wrPtr_q                <= wrPtr_q + PTR_ONE;
            end
            if (doPop)
                rdPtr_q <= rdPtr_q + PTR_ONE;
            if (s1Valid_q && fifoFull && !doPop)
                overflow_q <= 1'b1;
        end
    end

    assign head      = mem_q[rdPtr_q[AW-1:0]];
    assign sym_valid = !fifoEmpty;
    assign sym_code  = head[3:0];
    assign overflow  = overflow_q;
`ifdef QAM_SLICER_ERR_EN
    assign err_i = head[35:20];
    assign err_q = head[19:4];
`endif

endmodule

// File: tb/tb_qam_symbol_sampler.sv
// Scoreboard bench for qam_symbol_sampler: directed I/Q vectors push hand-derived codes, a monitor pops on each handshake.
module tb_qam_symbol_sampler;
    localparam int DATA_W = 32;
    localparam logic signed [31:0] THR = 32'sd1073741824;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [1:0]        baud_rate;
    logic [4:0]        sample_phase;
    logic              in_valid;
    logic signed [31:0] sample_i;
    logic signed [31:0] sample_q;
    logic              sym_valid;
    logic              sym_ready;
    logic [3:0]        sym_code;
    logic              overflow;

    int         checks = 0;
    int         errors = 0;
    int         popCount = 0;
    logic [3:0] expQ[$];

    // Reference symbol timing: counter, registered rate and strobe bookkeeping.
    int         mCnt = 0;
    logic [1:0] mBaud = 2'b00;
    int         strobesT = 0;
    logic       lastStrobe = 1'b0;

    always #5 clk = ~clk;

    qam_symbol_sampler #(.DATA_W(DATA_W), .THRESH(32'sd1073741824), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .baud_rate(baud_rate),
        .sample_phase(sample_phase), .in_valid(in_valid), .sample_i(sample_i),
        .sample_q(sample_q), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_code(sym_code), .overflow(overflow)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Gray level per axis code: 00 outer-negative, 01 inner-negative, 11 inner-positive, 10 outer-positive.
    function automatic logic signed [31:0] lvl(input logic [1:0] b);
        case (b)
            2'b00:   lvl = -32'sd1610612736;
            2'b01:   lvl = -32'sd536870912;
            2'b11:   lvl = 32'sd536870912;
            default: lvl = 32'sd1610612736;
        endcase
    endfunction

    function automatic logic [3:0] patCode(input int k);
        patCode = 4'((k * 7 + 3) % 16);
    endfunction

    task automatic applyStimulus(input logic en, input logic iv, input logic signed [31:0] si,
                                 input logic signed [31:0] sq, input logic [3:0] code, input logic keep);
        int mask;
        int ph;
        enable   = en;
        in_valid = iv;
        sample_i = si;
        sample_q = sq;
        case (baud_rate)
            2'b00:   mask = 31;
            2'b01:   mask = 15;
            2'b10:   mask = 7;
            default: mask = 3;
        endcase
        ph = int'(sample_phase) & mask;
        lastStrobe = 1'b0;
        if (baud_rate != mBaud) begin
            mCnt = 0;
        end else if (en && iv) begin
            if (mCnt == ph) lastStrobe = 1'b1;
            mCnt = (mCnt == mask) ? 0 : mCnt + 1;
        end
        mBaud = baud_rate;
        if (lastStrobe) begin
            if (keep) expQ.push_back(code);
            strobesT++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 32'sd0, 32'sd0, 4'd0, 1'b0);
    endtask

    task automatic runPattern(input int n, input int keepLimit);
        for (int k = 0; k < n; k++) begin
            logic [3:0] c;
            c = patCode(k);
            applyStimulus(1'b1, 1'b1, lvl(c[3:2]), lvl(c[1:0]), c, strobesT < keepLimit);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && sym_valid && sym_ready) begin
            popCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedSymbol: got code %0d, expected no symbol", sym_code);
            end else begin
                checkOutput("symCode", int'(sym_code), int'(expQ.pop_front()));
            end
        end
    end

    initial begin
        int firstK;
        int pops0;
        logic signed [31:0] bv[8];
        logic [1:0]         bc[8];

        reset = 1'b1; enable = 1'b0; in_valid = 1'b0; sym_ready = 1'b0;
        baud_rate = 2'b11; sample_phase = 5'd0; sample_i = '0; sample_q = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetValid", int'(sym_valid), 0);
        checkOutput("resetCode", int'(sym_code), 0);
        checkOutput("resetOverflow", int'(overflow), 0);
        reset = 1'b0;

        // Test 1: SPS=4 extremes, latency of first symbol.
        sym_ready = 1'b1;
        firstK = -1;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 1'b1, 32'sh7FFFFFFF, 32'sh80000000, 4'b1000, 1'b1);
            if (firstK < 0 && lastStrobe) begin
                firstK = k;
                checkOutput("t1NoEarlyValid", int'(sym_valid), 0);
            end else if (firstK >= 0 && k == firstK + 1) begin
                checkOutput("t1ValidLatency", int'(sym_valid), 1);
            end
        end
        idle(6);
        checkOutput("t1Drained", expQ.size(), 0);

        // Test 2: SPS=32, phase 5.
        baud_rate = 2'b00; sample_phase = 5'd5;
        pops0 = popCount;
        for (int k = 0; k < 70; k++)
            applyStimulus(1'b1, 1'b1, (mCnt == 5 && baud_rate == mBaud) ? 32'sd1000 : 32'sd0,
                          -32'sd1000, 4'b1101, 1'b1);
        idle(6);
        checkOutput("t2Symbols", popCount - pops0, 2);

        // Test 3: six strobes with the consumer stalled.
        sym_ready = 1'b0; baud_rate = 2'b11; sample_phase = 5'd0;
        strobesT = 0;
        pops0 = popCount;
        for (int k = 0; k < 40 && strobesT < 6; k++) begin
            logic [3:0] c;
            c = patCode(k);
            applyStimulus(1'b1, 1'b1, lvl(c[3:2]), lvl(c[1:0]), c, strobesT < 4);
        end
        idle(3);
        checkOutput("t3Overflow", int'(overflow), 1);
        checkOutput("t3HeldValid", int'(sym_valid), 1);
        sym_ready = 1'b1;
        idle(8);
        checkOutput("t3Delivered", popCount - pops0, 4);
        checkOutput("t3OverflowSticky", int'(overflow), 1);

        // Test 5: reset with three queued symbols and a live stage 1.
        sym_ready = 1'b0;
        strobesT = 0;
        for (int k = 0; k < 40 && strobesT < 4; k++) begin
            logic [3:0] c;
            c = patCode(k);
            applyStimulus(1'b1, 1'b1, lvl(c[3:2]), lvl(c[1:0]), c, 1'b1);
        end
        checkOutput("t5PreValid", int'(sym_valid), 1);
        reset = 1'b1;
        #1;
        checkOutput("t5ResetValid", int'(sym_valid), 0);
        checkOutput("t5ResetOverflow", int'(overflow), 0);
        expQ.delete();
        mCnt = 0; mBaud = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sym_ready = 1'b1;
        pops0 = popCount;
        idle(6);
        checkOutput("t5NoStale", popCount - pops0, 0);

        // Test 4: rate change 11 -> 10 mid-symbol with symbols queued.
        sym_ready = 1'b0; sample_phase = 5'd1;
        strobesT = 0;
        pops0 = popCount;
        for (int k = 0; k < 40 && strobesT < 2; k++) begin
            logic [3:0] c;
            c = patCode(k);
            applyStimulus(1'b1, 1'b1, lvl(c[3:2]), lvl(c[1:0]), c, 1'b1);
        end
        runPattern(1, 8);
        baud_rate = 2'b10;
        runPattern(12, 8);
        idle(3);
        checkOutput("t4NoOverflow", int'(overflow), 0);
        sym_ready = 1'b1;
        idle(8);
        checkOutput("t4Delivered", popCount - pops0, 4);

        // Test 6: enable held low freezes the counter.
        baud_rate = 2'b01; sample_phase = 5'd3;
        pops0 = popCount;
        runPattern(10, 99);
        for (int k = 0; k < 10; k++) begin
            logic [3:0] c;
            c = patCode(k + 5);
            applyStimulus(1'b0, 1'b1, lvl(c[3:2]), lvl(c[1:0]), c, 1'b0);
        end
        runPattern(20, 99);
        idle(6);
        checkOutput("t6Symbols", popCount - pops0, 2);

        // Test 7: decision thresholds at their exact boundaries.
        bv[0] = THR;          bc[0] = 2'b10;
        bv[1] = THR - 1;      bc[1] = 2'b11;
        bv[2] = 32'sd0;       bc[2] = 2'b11;
        bv[3] = -32'sd1;      bc[3] = 2'b01;
        bv[4] = -THR;         bc[4] = 2'b01;
        bv[5] = -THR - 1;     bc[5] = 2'b00;
        bv[6] = 32'sh7FFFFFFF; bc[6] = 2'b10;
        bv[7] = 32'sh80000000; bc[7] = 2'b00;
        baud_rate = 2'b11; sample_phase = 5'd0;
        pops0 = popCount;
        for (int j = 0; j < 8; j++)
            for (int r = 0; r < 4; r++)
                applyStimulus(1'b1, 1'b1, bv[j], bv[7-j], {bc[j], bc[7-j]}, 1'b1);
        idle(6);
        checkOutput("t7Symbols", popCount - pops0, 8);
        checkOutput("finalDrained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qam_symbol_sampler.md
Name: qam_symbol_sampler

Overview:
Receive-side counterpart of the transmit pulse-shaping filter bank. It takes matched-filtered I/Q samples at the 76800 Hz design sample rate and decimates them to the selected symbol rate (2400/4800/9600/19200 Bd). At each symbol instant it slices one 16-QAM decision and queues the 4-bit Gray symbol code in a 4-deep FIFO with a valid/ready output handshake.

Parameters:
DATA_W, 32, signed width of sample_i/sample_q.
THRESH, 32'sd1073741824, outer decision threshold; must be positive and less than 2^(DATA_W-1).
FIFO_DEPTH, 4, symbol FIFO depth; must be a power of 2, minimum 2.

Ports:
clk  in  1  sample clock, one potential sample per cycle (76800 Hz design rate)
reset  in  1  asynchronous, active-high reset
enable  in  1  high: sampler runs; low: counter held, no strobes
baud_rate  in  2  00=2400, 01=4800, 10=9600, 11=19200 Bd
sample_phase  in  5  symbol sampling offset in samples, masked to the current SPS
in_valid  in  1  sample_i/sample_q valid this cycle
sample_i  in  DATA_W  signed I sample
sample_q  in  DATA_W  signed Q sample
sym_valid  out  1  FIFO not empty
sym_ready  in  1  consumer accepts the head symbol
sym_code  out  4  {I bits[1:0], Q bits[1:0]} at the FIFO head
overflow  out  1  sticky; a symbol was dropped because the FIFO was full

Behaviour:
- Reset values: sym_valid=0, sym_code=0, overflow=0, FIFO empty, phase counter=0, slicer stage invalid.
- Samples per symbol (SPS): 32/16/8/4 for baud_rate 00/01/10/11. Effective phase is ph = sample_phase & (SPS-1).
- Phase counter cnt:
  - Advances only on enable && in_valid.
  - Wraps from SPS-1 to 0.
  - Held when enable=0.
- Strobe: enable && in_valid && cnt==ph.
- baud_rate change: a registered copy of baud_rate is compared every cycle. On a mismatch, cnt is forced to 0 and no strobe is generated that cycle. FIFO contents are kept.
- Stage 1 (strobe cycle N): sample_i and sample_q are registered, and a stage-valid flag is set.
- Stage 2 (cycle N+1): each axis is sliced with Gray mapping:
  - x < -THRESH → 00
  - -THRESH ≤ x < 0 → 01
  - 0 ≤ x < THRESH → 11
  - x ≥ THRESH → 10
  - Comparisons are signed at full DATA_W.
  - The code is written to the FIFO at the end of N+1. sym_valid rises in cycle N+2 if the FIFO was empty.
- FIFO handshake:
  - Pop on sym_valid && sym_ready.
  - sym_code always shows the head entry and is stable while sym_valid && !sym_ready.
- Simultaneous push and pop when full: both proceed, with no overflow.
- Push when full with no pop: the new symbol is dropped and overflow is set to 1. It clears only on reset.
- Pop when empty: ignored.
- Back-to-back strobes at SPS=4 must be sustained with sym_ready held at 1 (no loss).
- Reset mid-operation: all state returns to reset values immediately, including any in-flight stage-1 sample.

Optional Feature:
QAM_SLICER_ERR_EN:
- When defined, two extra outputs are added: err_i and err_q, 16-bit signed.
- Each carries the sliced sample minus its ideal level. Ideal levels are ±THRESH/2 for the inner points and ±3·THRESH/2 for the outer points.
- The error is arithmetic-shifted right by (DATA_W-16) and saturated to ±32767.
- Both values are stored in the FIFO alongside sym_code and follow the same handshake.
- When undefined, these ports and their FIFO storage do not exist. Symbol behaviour is identical in both builds.

Test Plan:
1. baud_rate=11, phase=0, in_valid=1 continuous, I=+2^31-1, Q=-2^31, sym_ready=1 → sym_code=4'b1000 every 4 cycles; first sym_valid 2 cycles after the first strobe.
2. baud_rate=00, sample_phase=5, I=+1000 only at cnt=5 (0 elsewhere), Q=-1000 → each symbol is code 4'b1101, one every 32 valid samples.
3. sym_ready=0, 6 strobes at baud_rate=11 → 4 symbols held in order, overflow=1, remaining 2 dropped; releasing sym_ready delivers exactly 4 symbols.
4. Switch baud_rate 11→10 mid-symbol → no strobe in the change cycle, next strobe at cnt==ph of the new 8-sample period, queued symbols intact.
5. Assert reset while the FIFO holds 3 symbols and stage 1 is valid → sym_valid=0 and overflow=0 immediately; no stale symbol appears after release.
6. enable=0 for 10 cycles with in_valid=1 → no symbols, cnt frozen; resuming continues from the frozen cnt.
